// File: rtl/adc_ctrl_pkg.sv
// Shared types and constants for the ADC capture sequencer.
package adc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_WAIT_TRIG,
    ST_CAPTURE,
    ST_DONE
  } state_e;

  localparam logic [1:0] TRIG_IMM  = 2'b00;
  localparam logic [1:0] TRIG_RISE = 2'b01;
  localparam logic [1:0] TRIG_FALL = 2'b10;
  localparam logic [1:0] TRIG_EXT  = 2'b11;

  localparam logic [1:0] CH_TEST = 2'b00;
  localparam logic [1:0] CH_AD0  = 2'b01;
  localparam logic [1:0] CH_AD1  = 2'b10;

endpackage

// File: rtl/adc_trig_detect.sv
// Trigger detector: remembers the previous decimated sample and flags a
// level crossing or external trigger on the current sample clock.
module adc_trig_detect
  import adc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_i,
  input  logic       load_i,
  input  logic       armed_i,
  input  logic [1:0] mode_i,
  input  logic [7:0] level_i,
  input  logic [7:0] cur_i,
  input  logic       ext_i,
  output logic       trig_hit_o
);

  logic [7:0] prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= '0;
    end else if (load_i) begin
      prev_q <= cur_i;
    end
  end

  always_comb begin
    trig_hit_o = 1'b0;
    if (sample_i && armed_i) begin
      case (mode_i)
        TRIG_RISE: trig_hit_o = (prev_q < level_i) && (cur_i >= level_i);
        TRIG_FALL: trig_hit_o = (prev_q >= level_i) && (cur_i < level_i);
        TRIG_EXT:  trig_hit_o = ext_i;
        default:   trig_hit_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC capture sequencer: decimates the formatter stream, waits for a trigger
// and streams a programmed number of samples into the capture FIFO.
module adc_capture_ctrl
  import adc_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned DEPTH_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         cfg_ch_sel,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [DEPTH_W-1:0] cfg_depth,
  input  logic [1:0]         cfg_trig_mode,
  input  logic [7:0]         cfg_trig_level,
  input  logic               ext_trig,
  output logic               ad_sample_en,
  output logic [1:0]         ch_sel,
  input  logic [15:0]        ad_out,
  input  logic               ad_out_valid,
  output logic               fifo_wr_en,
  output logic [15:0]        fifo_wr_data,
  input  logic               fifo_full,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [DEPTH_W-1:0] sample_cnt
);

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d, div_cfg_q, div_cfg_d;
  logic [DEPTH_W-1:0] depth_q, depth_d, cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d, ch_q, ch_d;
  logic [7:0]         level_q, level_d;
  logic               tick, tick_dly_q;
  logic               ovf_q, ovf_d;
  logic               wr_en_q, wr_en_d;
  logic [15:0]        wr_data_q, wr_data_d;
  logic               done_q, done_d, busy_q, busy_d, en_q, en_d;
  logic [1:0]         ch_sel_q, ch_sel_d;
  logic               active, sample, capture, trig_hit;

  assign active = (state_q == ST_PRIME) || (state_q == ST_WAIT_TRIG) ||
                  (state_q == ST_CAPTURE);
  assign tick   = active && (div_q == '0);
  // tick_dly_q lines the divider up with the formatter's registered output
  assign sample = active && tick_dly_q && ad_out_valid;

  adc_trig_detect u_trig (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_i   (sample),
    .load_i     (sample && ((state_q == ST_PRIME) || (state_q == ST_WAIT_TRIG))),
    .armed_i    (state_q == ST_WAIT_TRIG),
    .mode_i     (mode_q),
    .level_i    (level_q),
    .cur_i      (ad_out[7:0]),
    .ext_i      (ext_trig),
    .trig_hit_o (trig_hit)
  );

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    div_cfg_d = div_cfg_q;
    depth_d   = depth_q;
    mode_d    = mode_q;
    ch_d      = ch_q;
    level_d   = level_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    wr_en_d   = 1'b0;
    wr_data_d = '0;
    capture   = 1'b0;

    if (active) begin
      div_d = (div_q == div_cfg_q) ? '0 : div_q + DIV_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          div_cfg_d = cfg_div;
          depth_d   = cfg_depth;
          mode_d    = cfg_trig_mode;
          ch_d      = cfg_ch_sel;
          level_d   = cfg_trig_level;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          div_d     = '0;
          state_d   = ST_PRIME;
        end
      end
      ST_PRIME: begin
        if (sample) begin
          if (mode_q == TRIG_IMM) capture = 1'b1;
          else                    state_d = ST_WAIT_TRIG;
        end
      end
      ST_WAIT_TRIG: capture = trig_hit;
      ST_CAPTURE:   capture = sample;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase

    // The triggering sample is handled here so every entry path shares one write stage
    if (capture) begin
      if (depth_q == '0) begin
        state_d = ST_DONE;
      end else begin
        wr_en_d   = !fifo_full;
        wr_data_d = fifo_full ? '0 : ad_out;
        ovf_d     = ovf_q | fifo_full;
        cnt_d     = cnt_q + DEPTH_W'(1);
        state_d   = (cnt_d == depth_q) ? ST_DONE : ST_CAPTURE;
      end
    end

    if (abort) begin
      state_d   = ST_IDLE;
      wr_en_d   = 1'b0;
      wr_data_d = '0;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
    end

    done_d   = (state_q == ST_DONE) && !abort;
    busy_d   = (state_d != ST_IDLE);
    en_d     = (state_d == ST_PRIME) || (state_d == ST_WAIT_TRIG) ||
               (state_d == ST_CAPTURE);
    ch_sel_d = busy_d ? ch_d : CH_TEST;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      div_cfg_q  <= '0;
      depth_q    <= '0;
      mode_q     <= '0;
      ch_q       <= '0;
      level_q    <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      tick_dly_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      en_q       <= 1'b0;
      ch_sel_q   <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      div_cfg_q  <= div_cfg_d;
      depth_q    <= depth_d;
      mode_q     <= mode_d;
      ch_q       <= ch_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      tick_dly_q <= tick;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      en_q       <= en_d;
      ch_sel_q   <= ch_sel_d;
    end
  end

  assign ad_sample_en = en_q;
  assign ch_sel       = ch_sel_q;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign overflow     = ovf_q;
  assign sample_cnt   = cnt_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: formatter/FIFO environment model, vector table,
// corner-case sequences and randomized captures against a stream-level model.
module tb_adc_capture_ctrl;

  localparam int NJ = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [1:0]  cfg_ch_sel = '0, cfg_trig_mode = '0;
  logic [15:0] cfg_div = '0, cfg_depth = '0;
  logic [7:0]  cfg_trig_level = '0;
  logic        ext_trig = 1'b0, fifo_full = 1'b0, ad_out_valid = 1'b0;
  logic [15:0] ad_out = '0;
  logic        ad_sample_en, fifo_wr_en, busy, done, overflow;
  logic [1:0]  ch_sel;
  logic [15:0] fifo_wr_data, sample_cnt;

  adc_capture_ctrl #(.DIV_W(16), .DEPTH_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_ch_sel(cfg_ch_sel), .cfg_div(cfg_div), .cfg_depth(cfg_depth),
    .cfg_trig_mode(cfg_trig_mode), .cfg_trig_level(cfg_trig_level),
    .ext_trig(ext_trig), .ad_sample_en(ad_sample_en), .ch_sel(ch_sel),
    .ad_out(ad_out), .ad_out_valid(ad_out_valid), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full), .busy(busy),
    .done(done), .overflow(overflow), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  // Environment stream: j-th formatter output since enable rose
  logic [15:0] src [NJ];
  bit          ext_a [NJ];
  bit          full_a [NJ];
  int          fj = 0;
  bit          en_hold = 1'b0;

  always @(negedge clk) begin
    ad_out_valid = en_hold;
    if (en_hold) begin
      ad_out    = src[fj];
      ext_trig  = ext_a[fj];
      fifo_full = full_a[fj];
      if (fj < NJ - 1) fj++;
    end else begin
      fj        = 0;
      ext_trig  = 1'b0;
      fifo_full = 1'b0;
    end
    en_hold = ad_sample_en;
  end

  int          cyc = 0;
  logic [15:0] wr_d_q [$];
  int          wr_c_q [$];
  int          done_c_q [$];
  logic        done_busy, done_en;
  logic [1:0]  done_ch;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (fifo_wr_en) begin
      wr_d_q.push_back(fifo_wr_data);
      wr_c_q.push_back(cyc);
    end
    if (done) begin
      done_c_q.push_back(cyc);
      done_busy = busy;
      done_en   = ad_sample_en;
      done_ch   = ch_sel;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_busy"},  32'(busy), 0);
    check({pfx, "_en"},    32'(ad_sample_en), 0);
    check({pfx, "_ch"},    32'(ch_sel), 0);
    check({pfx, "_wren"},  32'(fifo_wr_en), 0);
    check({pfx, "_wdata"}, 32'(fifo_wr_data), 0);
    check({pfx, "_done"},  32'(done), 0);
    check({pfx, "_ovf"},   32'(overflow), 0);
    check({pfx, "_cnt"},   32'(sample_cnt), 0);
  endtask

  task automatic load_stream(input logic [15:0] base, input logic [15:0] step,
                             input int flo, input int fhi, input int elo, input int ehi);
    logic [15:0] v;
    v = base;
    for (int j = 0; j < NJ; j++) begin
      src[j]    = v;
      v         = v + step;
      full_a[j] = (j >= flo) && (j < fhi);
      ext_a[j]  = (j >= elo) && (j < ehi);
    end
  endtask

  // Index of the decimated sample that triggers; samples sit at j = k*(div+1)
  function automatic int model_trig(input logic [1:0] mode, input logic [7:0] lvl,
                                    input int unsigned d);
    int p;
    logic [7:0] a, b;
    p = int'(d) + 1;
    if (mode == 2'b00) return 0;
    for (int k = 1; k * p < NJ; k++) begin
      a = src[(k - 1) * p][7:0];
      b = src[k * p][7:0];
      if (mode == 2'b01 && a < lvl && b >= lvl) return k;
      if (mode == 2'b10 && a >= lvl && b < lvl) return k;
      if (mode == 2'b11 && ext_a[k * p]) return k;
    end
    return -1;
  endfunction

  task automatic start_cap(input logic [1:0] mode, input logic [1:0] ch, input int unsigned d,
                           input int unsigned depth, input logic [7:0] lvl, output int s);
    @(negedge clk);
    cfg_trig_mode  = mode;
    cfg_ch_sel     = ch;
    cfg_div        = 16'(d);
    cfg_depth      = 16'(depth);
    cfg_trig_level = lvl;
    start          = 1'b1;
    s              = cyc;
    wr_d_q.delete();
    wr_c_q.delete();
    done_c_q.delete();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_cap(input logic [1:0] mode, input logic [1:0] ch, input int unsigned d,
                         input int unsigned depth, input logic [7:0] lvl,
                         output int nwr, output logic [15:0] first,
                         output int cnt_o, output bit ovf_o);
    int t, s, p, idx, j, last;
    bit eo;
    t = model_trig(mode, lvl, d);
    p = int'(d) + 1;
    start_cap(mode, ch, d, depth, lvl, s);
    check("start_busy", 32'(busy), 1);
    check("start_en",   32'(ad_sample_en), 1);
    check("start_ch",   32'(ch_sel), 32'(ch));
    check("start_ovf",  32'(overflow), 0);
    check("start_cnt",  32'(sample_cnt), 0);
    for (int i = 0; i < 3000 && done_c_q.size() == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    idx = 0;
    eo  = 1'b0;
    for (int i = 0; i < int'(depth); i++) begin
      j = (t + i) * p;
      if (full_a[j]) begin
        eo = 1'b1;
      end else begin
        if (idx < wr_d_q.size()) begin
          check("wr_data",  32'(wr_d_q[idx]), 32'(src[j]));
          check("wr_cycle", wr_c_q[idx] - s, 3 + (t + i) * p);
        end
        idx++;
      end
    end
    check("wr_count",   wr_d_q.size(), idx);
    check("done_count", done_c_q.size(), 1);
    if (done_c_q.size() > 0) begin
      last = t + ((depth > 0) ? int'(depth) : 1) - 1;
      check("done_cycle", done_c_q[0] - s, 4 + last * p);
      check("done_busy",  32'(done_busy), 0);
      check("done_en",    32'(done_en), 0);
      check("done_ch",    32'(done_ch), 0);
    end
    check("end_cnt", 32'(sample_cnt), depth);
    check("end_ovf", 32'(overflow), 32'(eo));
    nwr   = wr_d_q.size();
    first = (wr_d_q.size() > 0) ? wr_d_q[0] : 16'h0;
    cnt_o = int'(sample_cnt);
    ovf_o = overflow;
    if (busy) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [1:0]  ch;
    int unsigned div;
    int unsigned depth;
    logic [7:0]  level;
    logic [15:0] base;
    logic [15:0] step;
    int          flo, fhi, elo, ehi;
    int          exp_writes;
    logic [15:0] exp_first;
    int          exp_cnt;
    bit          exp_ovf;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int nwr, cnt, s, t;
    logic [15:0] first;
    bit ovf, ok;
    logic [1:0] m, ch;
    int unsigned d, dep;
    logic [7:0] lvl;

    tbl[0] = '{2'b00, 2'b00, 0, 8,  8'h00, 16'h0000, 16'h0001, 0, 0, 0, 0, 8, 16'h0000, 8, 1'b0};
    tbl[1] = '{2'b01, 2'b01, 3, 4,  8'h80, 16'h1270, 16'h0001, 0, 0, 0, 0, 4, 16'h1280, 4, 1'b0};
    tbl[2] = '{2'b10, 2'b10, 0, 3,  8'h40, 16'h0550, 16'hFFF8, 0, 0, 0, 0, 3, 16'h0538, 3, 1'b0};
    tbl[3] = '{2'b00, 2'b01, 1, 10, 8'h00, 16'h0300, 16'h0001, 4, 10, 0, 0, 7, 16'h0300, 10, 1'b1};
    tbl[4] = '{2'b00, 2'b10, 0, 0,  8'h00, 16'h0400, 16'h0001, 0, 0, 0, 0, 0, 16'h0000, 0, 1'b0};
    tbl[5] = '{2'b11, 2'b00, 2, 2,  8'h00, 16'h0A00, 16'h0011, 0, 0, 5, 7, 2, 16'h0A66, 2, 1'b0};
    tbl[6] = '{2'b01, 2'b01, 0, 1,  8'hFF, 16'h00F8, 16'h0001, 0, 0, 0, 0, 1, 16'h00FF, 1, 1'b0};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      load_stream(tbl[i].base, tbl[i].step, tbl[i].flo, tbl[i].fhi, tbl[i].elo, tbl[i].ehi);
      run_cap(tbl[i].mode, tbl[i].ch, tbl[i].div, tbl[i].depth, tbl[i].level, nwr, first, cnt, ovf);
      check($sformatf("tbl%0d_writes", i), nwr, tbl[i].exp_writes);
      if (tbl[i].exp_writes > 0) check($sformatf("tbl%0d_first", i), 32'(first), 32'(tbl[i].exp_first));
      check($sformatf("tbl%0d_cnt", i), cnt, tbl[i].exp_cnt);
      check($sformatf("tbl%0d_ovf", i), 32'(ovf), 32'(tbl[i].exp_ovf));
    end

    // Abort mid-capture: samples at s+2..s+7 are kept, the one alongside abort is not
    load_stream(16'h2000, 16'h0001, 0, 0, 0, 0);
    start_cap(2'b00, 2'b01, 0, 20, 8'h00, s);
    while (cyc < s + 8) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_en",   32'(ad_sample_en), 0);
    check("abort_wren", 32'(fifo_wr_en), 0);
    check("abort_cnt",  32'(sample_cnt), 6);
    repeat (4) @(negedge clk);
    check("abort_writes", wr_d_q.size(), 6);
    check("abort_nodone", done_c_q.size(), 0);

    // Abort together with start in IDLE: start must not take effect
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abst_busy", 32'(busy), 0);
    check("abst_en",   32'(ad_sample_en), 0);
    check("abst_cnt",  32'(sample_cnt), 6);

    // Reset mid-capture after an overflow has been recorded
    load_stream(16'h3000, 16'h0001, 0, 3, 0, 0);
    start_cap(2'b00, 2'b01, 0, 20, 8'h00, s);
    while (cyc < s + 5) @(negedge clk);
    check("prerst_ovf", 32'(overflow), 1);
    check("prerst_ch",  32'(ch_sel), 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int r = 0; r < 25; r++) begin
      ok = 1'b0;
      for (int tr = 0; tr < 20 && !ok; tr++) begin
        m   = 2'($urandom_range(0, 3));
        ch  = 2'($urandom_range(0, 2));
        d   = $urandom_range(0, 5);
        dep = $urandom_range(0, 16);
        lvl = 8'($urandom_range(32, 224));
        for (int j = 0; j < NJ; j++) begin
          src[j]    = 16'($urandom);
          full_a[j] = ($urandom_range(0, 5) == 0);
          ext_a[j]  = ($urandom_range(0, 9) == 0);
        end
        t  = model_trig(m, lvl, d);
        ok = (t >= 0) && ((t + int'(dep) + 2) * (int'(d) + 1) + 4 < NJ);
      end
      if (!ok) m = 2'b00;
      run_cap(m, ch, d, dep, lvl, nwr, first, cnt, ovf);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
